// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of mem_port_arbiter: the arbiter is the master and the memory is the slave.
// Requests stay on the bus until m_ready; m_rvalid returns read data or a write acknowledge.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            m_req;
   logic            m_we;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_wdata;
   logic [DW/8-1:0] m_be;
   logic            m_ready;
   logic            m_rvalid;
   logic [DW-1:0]   m_rdata;

   modport master (
      output m_req, m_we, m_addr, m_wdata, m_be,
      input  m_ready, m_rvalid, m_rdata
   );

   modport slave (
      input  m_req, m_we, m_addr, m_wdata, m_be,
      output m_ready, m_rvalid, m_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (I) and load/store (D), one transaction at a time.
// Define ARB_RR_EN for round-robin arbitration; without it D always beats I.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [AW-1:0]     i_addr,
   output logic [DW-1:0]     i_rdata,
   output logic              i_valid,
   input  logic              fetch_flush,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [AW-1:0]     d_addr,
   input  logic [DW-1:0]     d_wdata,
   input  logic [DW/8-1:0]   d_be,
   output logic [DW-1:0]     d_rdata,
   output logic              d_valid,
   mem_port_arbiter_if.master mem,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              err
);
   localparam int BW = DW / 8;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t          state_q, state_d;
   logic            own_d_q, own_d_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            we_q, we_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [BW-1:0]   be_q, be_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            discard_q, discard_d;
   logic            err_q, err_d;
   logic            pick_d;

`ifdef ARB_RR_EN
   // Set when the most recent grant went to D.
   logic            last_d_q, last_d_d;

   always_ff @(posedge clk) begin
      if (!rst_n) last_d_q <= 1'b0;
      else        last_d_q <= last_d_d;
   end

   assign pick_d = d_req & (~i_req | ~last_d_q);
`else
   assign pick_d = d_req;
`endif

   always_comb begin
      state_d   = state_q;
      own_d_d   = own_d_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      rdata_d   = rdata_q;
      cnt_d     = cnt_q;
      discard_d = discard_q;
      err_d     = err_q;
`ifdef ARB_RR_EN
      last_d_d  = last_d_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (i_req | d_req) begin
               state_d   = S_REQ;
               own_d_d   = pick_d;
               addr_d    = pick_d ? d_addr : i_addr;
               we_d      = pick_d & d_we;
               wdata_d   = pick_d ? d_wdata : '0;
               be_d      = pick_d ? d_be : '1;
               discard_d = 1'b0;
               err_d     = 1'b0;
`ifdef ARB_RR_EN
               last_d_d  = pick_d;
`endif
            end
         end
         S_REQ: begin
            if (mem.m_ready) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            // A response arriving together with the timeout still counts as a normal completion.
            if (mem.m_rvalid) begin
               rdata_d = mem.m_rdata;
               state_d = S_RESP;
            end else if (cnt_q == TMO) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // The memory transaction always runs to completion; a squashed fetch just hides its result.
      if (fetch_flush && !own_d_q && state_q != S_IDLE) discard_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         own_d_q   <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         be_q      <= '0;
         rdata_q   <= '0;
         cnt_q     <= '0;
         discard_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         own_d_q   <= own_d_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         rdata_q   <= rdata_d;
         cnt_q     <= cnt_d;
         discard_q <= discard_d;
         err_q     <= err_d;
      end
   end

   assign mem.m_req   = (state_q == S_REQ);
   assign mem.m_we    = we_q & (state_q == S_REQ);
   assign mem.m_addr  = addr_q;
   assign mem.m_wdata = wdata_q;
   assign mem.m_be    = be_q;

   // A flush landing in the response cycle itself also suppresses the fetch result.
   assign i_valid   = (state_q == S_RESP) & ~own_d_q & ~discard_q & ~fetch_flush;
   assign d_valid   = (state_q == S_RESP) & own_d_q;
   assign i_rdata   = rdata_q;
   assign d_rdata   = rdata_q;
   assign err       = (state_q == S_RESP) & err_q;
   assign stall_if  = i_req & ~i_valid;
   assign stall_mem = d_req & ~d_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory model answers the bus, a monitor pops expected completions.
// Expected orderings follow ARB_RR_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int BW  = DW / 8;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic [DW-1:0] i_rdata;
   logic          i_valid;
   logic          fetch_flush = 1'b0;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [BW-1:0] d_be = '0;
   logic [DW-1:0] d_rdata;
   logic          d_valid;
   logic          stall_if, stall_mem, err;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (i_req),
      .i_addr      (i_addr),
      .i_rdata     (i_rdata),
      .i_valid     (i_valid),
      .fetch_flush (fetch_flush),
      .d_req       (d_req),
      .d_we        (d_we),
      .d_addr      (d_addr),
      .d_wdata     (d_wdata),
      .d_be        (d_be),
      .d_rdata     (d_rdata),
      .d_valid     (d_valid),
      .mem         (bus),
      .stall_if    (stall_if),
      .stall_mem   (stall_mem),
      .err         (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            is_d;
      logic [DW-1:0] data;
      bit            err;
   } sb_t;

   typedef struct {
      logic [AW-1:0] addr;
      bit            we;
      logic [BW-1:0] be;
      logic [DW-1:0] wdata;
   } mq_t;

   sb_t           sb_q[$];
   mq_t           mq_q[$];
   logic [DW-1:0] mem [0:1023];
   int            n_checks = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            done_cnt = 0;
   int            ack_cnt = 0;
   int            ack_cyc = 0;
   int            last_i_cyc = 0;
   int            last_d_cyc = 0;
   int            ready_wait = 0;
   bit            resp_en = 1'b1;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_fetch(input logic [AW-1:0] a);
      sb_q.push_back('{is_d: 1'b0, data: mem[a[11:2]], err: 1'b0});
      mq_q.push_back('{addr: a, we: 1'b0, be: {BW{1'b1}}, wdata: '0});
   endtask

   task automatic push_load(input logic [AW-1:0] a, input bit timeout);
      sb_q.push_back('{is_d: 1'b1, data: timeout ? '0 : mem[a[11:2]], err: timeout});
      mq_q.push_back('{addr: a, we: 1'b0, be: {BW{1'b1}}, wdata: '0});
   endtask

   // Waits for the completion count, dropping each request in its response cycle.
   task automatic wait_done(input int target, input int budget, input string tag);
      int k = 0;
      while (done_cnt < target && k < budget) begin
         @(negedge clk);
         k++;
         if (i_valid) i_req = 1'b0;
         if (d_valid) d_req = 1'b0;
      end
      check_value(tag, done_cnt, target);
   endtask

   task automatic wait_ack(input int a0, input string tag);
      int k = 0;
      while (ack_cnt == a0 && k < 30) begin
         @(negedge clk);
         k++;
      end
      check_value(tag, ack_cnt, a0 + 1);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Memory model: optional m_ready delay, response one cycle after acceptance.
   initial begin : mem_model
      logic          rst_s;
      bit            rd_pend;
      int            rdy_cnt;
      logic [DW-1:0] pend_data;
      mq_t           e;
      rd_pend = 1'b0;
      rdy_cnt = 0;
      pend_data = '0;
      bus.m_ready = 1'b0;
      bus.m_rvalid = 1'b0;
      bus.m_rdata = '0;
      forever begin
         @(posedge clk);
         rst_s = rst_n;
         #1;
         bus.m_ready = 1'b0;
         bus.m_rvalid = 1'b0;
         bus.m_rdata = '0;
         if (!rst_s) begin
            rd_pend = 1'b0;
            rdy_cnt = 0;
         end else if (rd_pend) begin
            if (resp_en) begin
               bus.m_rvalid = 1'b1;
               bus.m_rdata = pend_data;
            end
            rd_pend = 1'b0;
         end else if (bus.m_req) begin
            if (mq_q.size() == 0) begin
               check_value("m_req_unexpected", bus.m_req, 0);
            end else begin
               e = mq_q[0];
               check_value("m_addr", bus.m_addr, e.addr);
               check_value("m_we", bus.m_we, e.we);
               check_value("m_be", bus.m_be, e.be);
               if (e.we) check_value("m_wdata", bus.m_wdata, e.wdata);
               if (rdy_cnt < ready_wait) begin
                  rdy_cnt++;
               end else begin
                  bus.m_ready = 1'b1;
                  rdy_cnt = 0;
                  rd_pend = 1'b1;
                  ack_cyc = cyc;
                  ack_cnt++;
                  void'(mq_q.pop_front());
                  if (bus.m_we) begin
                     for (int b = 0; b < BW; b++)
                        if (bus.m_be[b]) mem[bus.m_addr[11:2]][8*b +: 8] = bus.m_wdata[8*b +: 8];
                     pend_data = '0;
                  end else begin
                     pend_data = mem[bus.m_addr[11:2]];
                  end
               end
            end
         end
      end
   end

   initial begin : monitor
      sb_t e;
      forever begin
         @(negedge clk);
         if (i_valid || d_valid) begin
            if (sb_q.size() == 0) begin
               check_value("valid_unexpected", {i_valid, d_valid}, 2'b00);
            end else begin
               e = sb_q.pop_front();
               check_value("valid_owner", {i_valid, d_valid}, e.is_d ? 2'b01 : 2'b10);
               check_value("rdata", e.is_d ? d_rdata : i_rdata, e.data);
               check_value("err", err, e.err);
               if (d_valid) last_d_cyc = cyc;
               else         last_i_cyc = cyc;
               $display("txn %0d: %s rdata=0x%08h err=%0b cycle=%0d", done_cnt,
                        d_valid ? "D" : "I", d_valid ? d_rdata : i_rdata, err, cyc);
               done_cnt++;
            end
         end else if (err) begin
            check_value("err_without_valid", err, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int            c0, base, k, a0, d_phase;
      logic [DW-1:0] old;
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      mem[64] = 32'hDEADBEEF;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_value("rst_ctrl", {bus.m_req, bus.m_we, i_valid, d_valid, err}, 5'b0);
      check_value("rst_m_addr", bus.m_addr, 0);
      check_value("rst_m_wdata", bus.m_wdata, 0);
      check_value("rst_m_be", bus.m_be, 0);
      check_value("rst_rdata", {i_rdata, d_rdata}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single fetch at minimum latency
      @(posedge clk); #1;
      c0 = cyc;
      i_req = 1'b1;
      i_addr = 32'h100;
      push_fetch(32'h100);
      @(negedge clk);
      check_value("t1_stall_c0", stall_if, 1);
      check_value("t1_mreq_c0", bus.m_req, 0);
      @(negedge clk);
      check_value("t1_mreq_c1", bus.m_req, 1);
      check_value("t1_stall_c1", stall_if, 1);
      @(negedge clk);
      check_value("t1_stall_c2", stall_if, 1);
      check_value("t1_ivalid_c2", i_valid, 0);
      @(negedge clk);
      check_value("t1_ivalid_c3", i_valid, 1);
      check_value("t1_rdata_c3", i_rdata, 32'hDEADBEEF);
      check_value("t1_stall_c3", stall_if, 0);
      i_req = 1'b0;
      wait_done(1, 5, "t1_done");
      check_value("t1_latency", last_i_cyc - c0, 3);

      // Simultaneous requests; D replaces its request once so two conflicts occur
      @(posedge clk); #1;
      base = done_cnt;
      i_req = 1'b1; i_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800; d_be = 4'hF;
`ifdef ARB_RR_EN
      push_load(32'h800, 1'b0); push_fetch(32'h40); push_load(32'h804, 1'b0);
`else
      push_load(32'h800, 1'b0); push_load(32'h804, 1'b0); push_fetch(32'h40);
`endif
      d_phase = 0;
      k = 0;
      while (done_cnt < base + 3 && k < 60) begin
         @(negedge clk);
         k++;
         if (d_valid) begin
            if (d_phase == 0) begin
               d_addr = 32'h804;
               d_phase = 1;
            end else begin
               d_req = 1'b0;
            end
         end
         if (i_valid) i_req = 1'b0;
      end
      check_value("t2_done", done_cnt, base + 3);
`ifdef ARB_RR_EN
      check_value("t2_gap", last_d_cyc - last_i_cyc, 4);
`else
      check_value("t2_gap", last_i_cyc - last_d_cyc, 4);
`endif

      // Store held through three cycles without m_ready
      @(posedge clk); #1;
      base = done_cnt;
      ready_wait = 3;
      old = mem[128];
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_be = 4'b0011; d_wdata = 32'h1234;
      sb_q.push_back('{is_d: 1'b1, data: '0, err: 1'b0});
      mq_q.push_back('{addr: 32'h200, we: 1'b1, be: 4'b0011, wdata: 32'h1234});
      wait_done(base + 1, 20, "t3_done");
      check_value("t3_mem", mem[128], {old[31:16], 16'h1234});
      check_value("t3_ack_to_valid", last_d_cyc - ack_cyc, 2);
      d_we = 1'b0; d_be = 4'hF;
      ready_wait = 0;

      // Timeout: memory never responds
      @(posedge clk); #1;
      base = done_cnt;
      resp_en = 1'b0;
      d_req = 1'b1; d_addr = 32'h808;
      push_load(32'h808, 1'b1);
      wait_done(base + 1, 30, "t5_done");
      check_value("t5_latency", last_d_cyc - ack_cyc, TMO + 2);
      resp_en = 1'b1;

      // Flush during WAIT of a fetch, then a normal load
      @(posedge clk); #1;
      a0 = ack_cnt;
      i_req = 1'b1; i_addr = 32'h300;
      mq_q.push_back('{addr: 32'h300, we: 1'b0, be: {BW{1'b1}}, wdata: '0});
      wait_ack(a0, "t4_ack");
      @(posedge clk); #1;
      fetch_flush = 1'b1;
      i_req = 1'b0;
      @(posedge clk); #1;
      fetch_flush = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check_value("t4_no_ivalid", i_valid, 0);
      end
      @(posedge clk); #1;
      base = done_cnt;
      d_req = 1'b1; d_addr = 32'h80C;
      push_load(32'h80C, 1'b0);
      wait_done(base + 1, 20, "t4_load_done");

      // Reset asserted while waiting for a response
      @(posedge clk); #1;
      a0 = ack_cnt;
      resp_en = 1'b0;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h210; d_be = 4'hF; d_wdata = 32'hAAAA5555;
      mq_q.push_back('{addr: 32'h210, we: 1'b1, be: 4'hF, wdata: 32'hAAAA5555});
      wait_ack(a0, "t6_ack");
      @(posedge clk); #1;
      rst_n = 1'b0;
      d_req = 1'b0; d_we = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check_value("t6_ctrl", {bus.m_req, bus.m_we, i_valid, d_valid, err, stall_mem}, 6'b0);
      check_value("t6_m_addr", bus.m_addr, 0);
      check_value("t6_m_wdata", bus.m_wdata, 0);
      check_value("t6_m_be", bus.m_be, 0);
      check_value("t6_rdata", {i_rdata, d_rdata}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      resp_en = 1'b1;
      repeat (8) @(posedge clk);
      #1;

      // Recovery fetch after reset
      base = done_cnt;
      i_req = 1'b1; i_addr = 32'h104;
      push_fetch(32'h104);
      wait_done(base + 1, 20, "t7_done");
      @(posedge clk); #1;

      check_value("sb_empty", sb_q.size(), 0);
      check_value("mq_empty", mq_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
